// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HOLD = 1'b1
    } fetch_state_e;

    localparam logic [31:0] INSTR_NOP     = 32'h0000_0013;
    localparam logic [31:0] PC_STEP       = 32'd4;
    localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/fetch_hold_buf.sv
// Skid register for the instruction/PC pair that decode refused while stalled.
module fetch_hold_buf (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_load,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc
);

    // Capture on load; reset clears so a held instruction cannot survive reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_instr <= '0;
            o_pc    <= '0;
        end else if (i_load) begin
            o_instr <= i_instr;
            o_pc    <= i_pc;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: sequential PC generation, one-cycle-latency memory
// response tracking, stall skid via a hold buffer, and redirect handling.
// Optional accept counter on o_fetch_cnt when FETCH_UNIT_PERF_EN is defined.
//
// state | meaning
// RUN   | outputs come straight from the memory response (rsp_vld_q/rsp_pc_q)
// HOLD  | decode stalled on a valid instruction; outputs come from the hold buffer
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    output logic [31:0] o_imem_addr,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_stall,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc4
`ifdef FETCH_UNIT_PERF_EN
    ,
    output logic [31:0] o_fetch_cnt
`endif
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  rsp_pc_q, rsp_pc_d;
    logic         rsp_vld_q, rsp_vld_d;
    logic [31:0]  hold_instr_q, hold_pc_q;
    logic         hold_load;
    logic         valid_raw;
    logic [31:0]  instr_raw;

    assign o_imem_addr = pc_q;
    assign o_pc4       = o_pc + PC_STEP;

    fetch_hold_buf u_hold_buf (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_load  (hold_load),
        .i_instr (o_instr),
        .i_pc    (o_pc),
        .o_instr (hold_instr_q),
        .o_pc    (hold_pc_q)
    );

    // State and PC registers; reset dominates redirect and stall.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= RUN;
            pc_q      <= RESET_PC;
            rsp_pc_q  <= '0;
            rsp_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            rsp_pc_q  <= rsp_pc_d;
            rsp_vld_q <= rsp_vld_d;
        end
    end

    // Output selection and next-state/PC decisions; redirect outranks stall.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        rsp_pc_d  = rsp_pc_q;
        rsp_vld_d = rsp_vld_q;
        hold_load = 1'b0;
        valid_raw = rsp_vld_q;
        instr_raw = i_imem_rdata;
        o_pc      = rsp_pc_q;

        case (state_q)
            RUN: begin
                valid_raw = rsp_vld_q;
                instr_raw = i_imem_rdata;
                o_pc      = rsp_pc_q;
            end
            HOLD: begin
                valid_raw = 1'b1;
                instr_raw = hold_instr_q;
                o_pc      = hold_pc_q;
            end
            default: begin
                valid_raw = 1'b0;
            end
        endcase

        o_valid = valid_raw && !i_redirect;
        o_instr = o_valid ? instr_raw : INSTR_NOP;

        if (i_redirect) begin
            state_d   = RUN;
            pc_d      = i_redirect_pc & PC_ALIGN_MASK;
            rsp_pc_d  = pc_q;
            rsp_vld_d = 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    rsp_pc_d  = pc_q;
                    rsp_vld_d = 1'b1;
                    if (valid_raw && i_stall) begin
                        // pc_q stays put so its read data is still on the bus when we leave HOLD
                        hold_load = 1'b1;
                        state_d   = HOLD;
                    end else begin
                        pc_d = pc_q + PC_STEP;
                    end
                end
                HOLD: begin
                    if (!i_stall) begin
                        state_d   = RUN;
                        pc_d      = pc_q + PC_STEP;
                        rsp_pc_d  = pc_q;
                        rsp_vld_d = 1'b1;
                    end
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

`ifdef FETCH_UNIT_PERF_EN
    logic accept;
    assign accept = o_valid && !i_stall;

    // Count accepted instructions; wraps naturally at 2^32.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_fetch_cnt <= '0;
        end else if (accept) begin
            o_fetch_cnt <= o_fetch_cnt + 32'd1;
        end
    end
`else
    // No accept counter in this build.
`endif

endmodule
